// File: rtl/snake_head_ctrl_if.sv
// Bundle of strobes into and head state out of the snake head controller.
// The master side drives the strobes; the slave side (the controller) drives the head state.
interface snake_head_ctrl_if;
  logic       tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       start;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       moved;
  logic       game_over;
  logic [9:0] steps;

  modport master (
    output tick, btn_up, btn_down, btn_left, btn_right, start,
    input  head_x, head_y, dir, moved, game_over, steps
  );

  modport slave (
    input  tick, btn_up, btn_down, btn_left, btn_right, start,
    output head_x, head_y, dir, moved, game_over, steps
  );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head controller: steps the head one cell per tick in the committed direction,
// filters reversal requests and stops in OVER when a step would leave the playfield.
module snake_head_ctrl #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24
) (
  input logic               clock,
  input logic               reset_n,
  snake_head_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [4:0] START_X = 5'(GRID_W / 2);
  localparam logic [4:0] START_Y = 5'(GRID_H / 2);
  localparam logic [4:0] MAX_X   = 5'(GRID_W - 1);
  localparam logic [4:0] MAX_Y   = 5'(GRID_H - 1);

  state_t     state_q, state_d;
  logic [4:0] headX_q, headX_d;
  logic [4:0] headY_q, headY_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] pending_q, pending_d;
  logic [9:0] steps_q, steps_d;
  logic       moved_q, moved_d;

  logic       reqValid;
  logic       reqLegal;
  logic [1:0] reqDir;
  logic [1:0] nextDir;
  logic       stepOk;
  logic [4:0] stepX;
  logic [4:0] stepY;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      headX_q   <= START_X;
      headY_q   <= START_Y;
      dir_q     <= DIR_RIGHT;
      pending_q <= DIR_RIGHT;
      steps_q   <= '0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      headX_q   <= headX_d;
      headY_q   <= headY_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      steps_q   <= steps_d;
      moved_q   <= moved_d;
    end
  end

  // Only the highest-priority button is considered; flipping bit 0 gives the reverse direction.
  always_comb begin
    reqValid = 1'b1;
    reqDir   = DIR_RIGHT;
    if (bus.btn_up)         reqDir = DIR_UP;
    else if (bus.btn_down)  reqDir = DIR_DOWN;
    else if (bus.btn_left)  reqDir = DIR_LEFT;
    else if (bus.btn_right) reqDir = DIR_RIGHT;
    else                    reqValid = 1'b0;
    reqLegal = reqValid && (reqDir != (dir_q ^ 2'b01));
    nextDir  = reqLegal ? reqDir : pending_q;
  end

  always_comb begin
    stepX  = headX_q;
    stepY  = headY_q;
    stepOk = 1'b0;
    case (nextDir)
      DIR_UP:    begin stepOk = (headY_q != 5'd0);  stepY = headY_q - 5'd1; end
      DIR_DOWN:  begin stepOk = (headY_q != MAX_Y); stepY = headY_q + 5'd1; end
      DIR_LEFT:  begin stepOk = (headX_q != 5'd0);  stepX = headX_q - 5'd1; end
      default:   begin stepOk = (headX_q != MAX_X); stepX = headX_q + 5'd1; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.tick && !stepOk) state_d = OVER;
      OVER:    if (bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A blocked step leaves head, dir and steps frozen; only the state moves to OVER.
  always_comb begin
    headX_d   = headX_q;
    headY_d   = headY_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    steps_d   = steps_q;
    moved_d   = 1'b0;
    case (state_q)
      IDLE: begin
        headX_d   = START_X;
        headY_d   = START_Y;
        dir_d     = DIR_RIGHT;
        pending_d = DIR_RIGHT;
        steps_d   = '0;
      end
      RUN: begin
        pending_d = nextDir;
        if (bus.tick && stepOk) begin
          headX_d = stepX;
          headY_d = stepY;
          dir_d   = nextDir;
          moved_d = 1'b1;
          if (steps_q != 10'h3FF) steps_d = steps_q + 10'd1;
        end
      end
      OVER: begin
        if (bus.start) begin
          headX_d   = START_X;
          headY_d   = START_Y;
          dir_d     = DIR_RIGHT;
          pending_d = DIR_RIGHT;
          steps_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.head_x    = headX_q;
  assign bus.head_y    = headY_q;
  assign bus.dir       = dir_q;
  assign bus.moved     = moved_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.steps     = steps_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl; each expected vector is packed as
// {head_x, head_y, dir, steps, moved, game_over} and computed by hand.
module tb_snake_head_ctrl;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  snake_head_ctrl_if bus ();

  snake_head_ctrl #(.GRID_W(32), .GRID_H(24)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] pack(input int x, input int y, input int d,
                                       input int s, input int m, input int g);
    return {5'(x), 5'(y), 2'(d), 10'(s), 1'(m), 1'(g)};
  endfunction

  function automatic logic [23:0] snap();
    return {bus.head_x, bus.head_y, bus.dir, bus.steps, bus.moved, bus.game_over};
  endfunction

  // Holds the given strobes for one clock cycle, returning at the falling edge after it.
  task automatic applyStimulus(input logic t, input logic up, input logic dn,
                               input logic lf, input logic rt, input logic st);
    @(negedge clock);
    bus.tick = t; bus.btn_up = up; bus.btn_down = dn;
    bus.btn_left = lf; bus.btn_right = rt; bus.start = st;
    @(negedge clock);
    bus.tick = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] want;
    want = pack(16, 12, 3, 0, 0, 0);
    reset_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 1);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL reset_values got %h want %h", snap(), want);
    end
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL idle_ignores_tick got %h want %h", snap(), want);
    end
  endtask

  task automatic test_basic_steps();
    logic [23:0] want;
    applyStimulus(0, 0, 0, 0, 0, 1);
    want = pack(16, 12, 3, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL start_run got %h want %h", snap(), want);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      want = pack(17 + i, 12, 3, i + 1, 1, 0);
      checks++;
      if (snap() !== want) begin
        errors++; $display("[TB] FAIL step%0d_moved got %h want %h", i, snap(), want);
      end
      @(negedge clock);
      want = pack(17 + i, 12, 3, i + 1, 0, 0);
      checks++;
      if (snap() !== want) begin
        errors++; $display("[TB] FAIL step%0d_pulse_end got %h want %h", i, snap(), want);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reversal();
    logic [23:0] want;
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(20, 12, 3, 4, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL reverse_dropped got %h want %h", snap(), want);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(20, 11, 0, 5, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL pending_up got %h want %h", snap(), want);
    end
    // down beats right but is a reversal of up, so the whole request is dropped
    applyStimulus(1, 0, 1, 0, 1, 0);
    want = pack(20, 10, 0, 6, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL winner_only got %h want %h", snap(), want);
    end
  endtask

  task automatic test_priority();
    logic [23:0] want;
    applyStimulus(1, 0, 0, 1, 0, 0);
    want = pack(19, 10, 2, 7, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL same_cycle_left got %h want %h", snap(), want);
    end
    applyStimulus(1, 1, 0, 0, 1, 0);
    want = pack(19, 9, 0, 8, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL up_beats_right got %h want %h", snap(), want);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(19, 8, 0, 9, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL start_in_run got %h want %h", snap(), want);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] want;
    @(negedge clock);
    bus.tick = 1'b1;
    @(negedge clock);
    want = pack(19, 7, 0, 10, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL b2b_first got %h want %h", snap(), want);
    end
    @(negedge clock);
    bus.tick = 1'b0;
    want = pack(19, 6, 0, 11, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL b2b_second got %h want %h", snap(), want);
    end
    @(negedge clock);
    want = pack(19, 6, 0, 11, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL b2b_settle got %h want %h", snap(), want);
    end
  endtask

  task automatic test_boundary();
    logic [23:0] want;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(31, 12, 3, 15, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL edge_reached got %h want %h", snap(), want);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(31, 12, 3, 15, 0, 1);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL wall_over got %h want %h", snap(), want);
    end
    applyStimulus(1, 0, 1, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL over_holds got %h want %h", snap(), want);
    end
  endtask

  task automatic test_over_restart();
    logic [23:0] want;
    applyStimulus(0, 0, 0, 0, 0, 1);
    want = pack(16, 12, 3, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL over_to_idle got %h want %h", snap(), want);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL idle_tick got %h want %h", snap(), want);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    want = pack(17, 12, 3, 1, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL rerun_step got %h want %h", snap(), want);
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] want;
    applyStimulus(1, 1, 0, 0, 0, 0);
    want = pack(17, 11, 0, 2, 1, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL pre_reset got %h want %h", snap(), want);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    want = pack(16, 12, 3, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL async_reset got %h want %h", snap(), want);
    end
    applyStimulus(1, 0, 0, 0, 0, 1);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checks++;
    if (snap() !== want) begin
      errors++; $display("[TB] FAIL post_reset_idle got %h want %h", snap(), want);
    end
  endtask

  // Scenarios run in order and share the head position left by the previous one.
  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.tick = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.start = 1'b0;
    test_reset();
    test_basic_steps();
    test_reversal();
    test_priority();
    test_back_to_back();
    test_boundary();
    test_over_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_head_ctrl.md
SNAKE_HEAD_CTRL -- requirements
Module: snake_head_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 32, playfield width in cells (legal range 2..32).
REQ-002 SHALL have parameter GRID_H, default 24, playfield height in cells (legal range 2..32).
REQ-003 SHALL have port clock  input  1  the single clock for the block; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick  input  1  one-cycle move-strobe pulse from the upstream ten-bit rate counter (asserted when its count wraps to 0).
REQ-006 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  debounced one-cycle direction pulses.
REQ-007 SHALL have port start  input  1  one-cycle start/restart pulse.
REQ-008 SHALL have ports head_x, head_y  output  5 each  current head cell; x = column, y = row, y=0 is the top row.
REQ-009 SHALL have port dir  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-010 SHALL have port moved  output  1  one-cycle pulse after each successful head step.
REQ-011 SHALL have port game_over  output  1  high while in state OVER.
REQ-012 SHALL have port steps  output  10  count of successful steps since the last IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and OVER; all outputs registered.
REQ-014 IDLE: head = (GRID_W/2, GRID_H/2), dir = right, pending = right, steps = 0, moved = 0; start -> RUN on the next edge; tick and buttons ignored.
REQ-015 RUN: a button pulse SHALL load pending direction unless it is the opposite of the committed dir (up/down, left/right); opposite requests are dropped.
REQ-016 Simultaneous button pulses: priority up > down > left > right; only the winner is evaluated, and if it is illegal (reversal) the cycle's request is dropped.
REQ-017 RUN with tick=1: next_dir = the request from the same cycle if it is legal, else pending; the head moves one cell in next_dir; dir <= next_dir, all on that same edge.
REQ-018 A step SHALL change only one coordinate by exactly 1 (up y-1, down y+1, left x-1, right x+1); no wrap-around.
REQ-019 If the step would leave 0..GRID_W-1 or 0..GRID_H-1: transition to OVER; head, steps and dir hold; moved stays 0.
REQ-020 On a successful step: moved = 1 for exactly the cycle following the tick edge; steps += 1, saturating at 1023.
REQ-021 OVER: all state holds; tick and buttons ignored; start -> IDLE (full IDLE values); a second start is needed to re-enter RUN.
REQ-022 start in RUN SHALL be ignored.
REQ-023 tick is assumed to be at most one cycle wide; back-to-back ticks each produce one step.

Reset
REQ-024 reset_n low SHALL force, asynchronously and at any time including mid-RUN: state IDLE, head (GRID_W/2, GRID_H/2), dir = 11, pending = right, steps = 0, moved = 0, game_over = 0.
REQ-025 Release of reset_n SHALL take effect on the next rising clock edge; no inputs are acted on while reset_n is low.

Verification
REQ-026 Reset, start, then 3 ticks spaced 4 cycles apart -> head (19,12), dir 11, steps 3, three 1-cycle moved pulses, each in the cycle after its tick.
REQ-027 In RUN with dir right: btn_left then tick -> head x+1, dir stays 11; btn_up then tick -> y decreases by 1, dir 00.
REQ-028 btn_up and btn_right in the same cycle as a tick, with dir left -> up wins, head y-1 on that tick edge, dir 00.
REQ-029 From (16,12) moving right: 15 ticks -> (31,12), steps 15; 16th tick -> game_over 1, head (31,12), no moved pulse, steps 15.
REQ-030 In OVER, start -> IDLE with head (16,12), steps 0, game_over 0; a tick in IDLE -> no change.
REQ-031 reset_n pulsed low mid-RUN between clock edges -> outputs reach their reset values immediately, without waiting for a clock edge.
